// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite slave wrapping a parametrised file of RW/RO registers
// Ports: ACLK/ARESETn clock and async active-low reset; AW/W/B and AR/R AXI4-Lite slave channels;
//        hw_status supplies RO register values, reg_q exposes RW registers (RO slices 0),
//        wr_pulse strobes for one cycle per successfully written register.
module axi_lite_regfile_slave #(
  parameter int DW = 32,
  parameter int AW = 16,
  parameter int NREG = 8,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             AWVALID,
  output logic             AWREADY,
  input  logic [AW-1:0]    AWADDR,
  input  logic             WVALID,
  output logic             WREADY,
  input  logic [DW-1:0]    WDATA,
  input  logic [DW/8-1:0]  WSTRB,
  output logic             BVALID,
  input  logic             BREADY,
  output logic [1:0]       BRESP,
  input  logic             ARVALID,
  output logic             ARREADY,
  input  logic [AW-1:0]    ARADDR,
  output logic             RVALID,
  input  logic             RREADY,
  output logic [DW-1:0]    RDATA,
  output logic [1:0]       RRESP,
  input  logic [NREG*DW-1:0] hw_status,
  output logic [NREG*DW-1:0] reg_q,
  output logic [NREG-1:0]  wr_pulse
);
  localparam int IW = AW - 2;
  localparam int NB = DW / 8;
  logic [DW-1:0] regs [NREG];
  logic aw_held, w_held, bvalid, rvalid;
  logic [IW-1:0] aw_idx, c_idx, r_idx;
  logic [DW-1:0] w_data, c_data, r_data;
  logic [NB-1:0] w_strb, c_strb;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [NREG-1:0] c_sel, r_hit;
  logic unused_addr_lsbs;
  assign AWREADY = ~aw_held & ~bvalid;
  assign WREADY = ~w_held & ~bvalid;
  assign ARREADY = ~rvalid;
  assign BVALID = bvalid;
  assign RVALID = rvalid;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;
  // a channel arriving in the commit cycle is used directly instead of via its holding register
  assign c_idx = aw_held ? aw_idx : AWADDR[AW-1:2];
  assign c_data = w_held ? w_data : WDATA;
  assign c_strb = w_held ? w_strb : WSTRB;
  assign commit = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid;
  assign r_idx = ARADDR[AW-1:2];
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};
  // c_sel is empty for out-of-range or RO targets, which is what makes the write SLVERR
  always_comb begin
    c_sel = '0;
    r_hit = '0;
    r_data = '0;
    for (int i = 0; i < NREG; i++) begin
      c_sel[i] = (c_idx == IW'(i)) & ~RO_MASK[i];
      r_hit[i] = r_idx == IW'(i);
      r_data = r_data | (r_hit[i] ? (RO_MASK[i] ? hw_status[i*DW +: DW] : regs[i]) : '0);
    end
  end
  for (genvar i = 0; i < NREG; i++) begin : g_q
    assign reg_q[i*DW +: DW] = RO_MASK[i] ? '0 : regs[i];
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      bvalid <= 1'b0;
      BRESP <= 2'b00;
      wr_pulse <= '0;
      rvalid <= 1'b0;
      RDATA <= '0;
      RRESP <= 2'b00;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      aw_held <= ~commit & (aw_held | aw_hs);
      w_held <= ~commit & (w_held | w_hs);
      if (aw_hs) aw_idx <= AWADDR[AW-1:2];
      if (w_hs) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      bvalid <= commit | (bvalid & ~BREADY);
      if (commit) BRESP <= |c_sel ? 2'b00 : 2'b10;
      wr_pulse <= commit ? c_sel : '0;
      for (int i = 0; i < NREG; i++)
        for (int k = 0; k < NB; k++)
          if (commit & c_sel[i] & c_strb[k]) regs[i][8*k +: 8] <= c_data[8*k +: 8];
      rvalid <= ar_hs | (rvalid & ~RREADY);
      if (ar_hs) begin
        RDATA <= r_data;
        RRESP <= |r_hit ? 2'b00 : 2'b10;
      end
    end
endmodule
